// File: rtl/mem_arbiter_mp.sv
// mem_arbiter_mp: urgent-first round-robin arbiter issuing fixed-length MIG command bursts
module mem_arbiter_mp #(
    parameter int ADDR_W    = 29,
    parameter int MASK_W    = 16,
    parameter int NUM_WR    = 2,
    parameter int NUM_RD    = 2,
    parameter int BURST_LEN = 4,
    parameter int ADDR_STEP = 8,
    localparam int WW = NUM_WR > 1 ? $clog2(NUM_WR) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     calib_done,
    input  logic                     app_rdy,
    output logic                     app_en,
    output logic [2:0]               app_cmd,
    output logic [ADDR_W-1:0]        app_addr,
    input  logic                     app_wdf_rdy,
    output logic                     app_wdf_wren,
    output logic                     app_wdf_end,
    output logic [MASK_W-1:0]        app_wdf_mask,
    output logic [WW-1:0]            wr_sel,
    output logic [NUM_WR-1:0]        wdata_rd_en,
    input  logic [NUM_WR-1:0]        wr_req,
    input  logic [NUM_WR-1:0]        wr_urgent,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    output logic [NUM_WR-1:0]        wr_ack,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD-1:0]        rd_urgent,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_ack,
    output logic                     busy
);
    localparam int N  = NUM_WR + NUM_RD;
    localparam int PW = $clog2(N);
    localparam int RW = NUM_RD > 1 ? $clog2(NUM_RD) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {CALIB, IDLE, WR_DATA, WR_CMD, RD_CMD} state_t;

    state_t              state_q, state_d;
    logic                app_en_q, app_en_d, wren_q, wren_d;
    logic [2:0]          app_cmd_q, app_cmd_d;
    logic [ADDR_W-1:0]   app_addr_q, app_addr_d;
    logic [WW-1:0]       wr_sel_q, wr_sel_d, wr_idx;
    logic [RW-1:0]       rd_sel_q, rd_sel_d, rd_idx;
    logic [NUM_WR-1:0]   wdata_rd_en_q, wdata_rd_en_d, wr_ack_q, wr_ack_d;
    logic [NUM_RD-1:0]   rd_ack_q, rd_ack_d;
    logic [PW-1:0]       rr_q, rr_d, win, rd_off;
    logic [PW:0]         j;
    logic [BW-1:0]       beat_q, beat_d;
    logic [N-1:0]        req, urg, cand;
    logic                found, win_wr, accept, last;

    // Urgent requesters mask out the rest; search starts one past the last winner.
    always_comb begin
        req   = {rd_req, wr_req};
        urg   = req & {rd_urgent, wr_urgent};
        cand  = |urg ? urg : req;
        win   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= N; k++) begin
            j = {1'b0, rr_q} + (PW + 1)'(k);
            j = j >= (PW + 1)'(N) ? j - (PW + 1)'(N) : j;
            if (!found && cand[j[PW-1:0]]) begin
                win   = j[PW-1:0];
                found = 1'b1;
            end
        end
    end

    assign win_wr = win < PW'(NUM_WR);
    assign wr_idx = win[WW-1:0];
    assign rd_off = win - PW'(NUM_WR);
    assign rd_idx = rd_off[RW-1:0];
    assign accept = app_en_q & app_rdy;
    assign last   = beat_q == BW'(1);

    always_comb begin
        state_d       = state_q;
        app_en_d      = app_en_q;
        app_cmd_d     = app_cmd_q;
        app_addr_d    = app_addr_q;
        wren_d        = wren_q;
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        rr_d          = rr_q;
        beat_d        = beat_q;
        wdata_rd_en_d = '0;
        wr_ack_d      = '0;
        rd_ack_d      = '0;
        case (state_q)
            CALIB: state_d = calib_done ? IDLE : CALIB;
            IDLE: if (|req) begin
                rr_d       = win;
                beat_d     = BW'(BURST_LEN);
                app_addr_d = win_wr ? wr_addr[int'(wr_idx)*ADDR_W +: ADDR_W]
                                    : rd_addr[int'(rd_idx)*ADDR_W +: ADDR_W];
                if (win_wr) begin
                    wr_sel_d      = wr_idx;
                    wdata_rd_en_d = NUM_WR'(1) << wr_idx;
                    wren_d        = 1'b1;
                    state_d       = WR_DATA;
                end else begin
                    rd_sel_d  = rd_idx;
                    app_en_d  = 1'b1;
                    app_cmd_d = 3'b001;
                    state_d   = RD_CMD;
                end
            end
            WR_DATA: if (app_wdf_rdy) begin
                wren_d    = 1'b0;
                app_en_d  = 1'b1;
                app_cmd_d = 3'b000;
                state_d   = WR_CMD;
            end
            WR_CMD: if (accept) begin
                wr_ack_d = NUM_WR'(1) << wr_sel_q;
                beat_d   = beat_q - BW'(1);
                app_en_d = 1'b0;
                if (!last) begin
                    app_addr_d    = app_addr_q + ADDR_W'(ADDR_STEP);
                    wdata_rd_en_d = NUM_WR'(1) << wr_sel_q;
                    wren_d        = 1'b1;
                    state_d       = WR_DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_CMD: if (accept) begin
                rd_ack_d   = NUM_RD'(1) << rd_sel_q;
                beat_d     = beat_q - BW'(1);
                app_addr_d = last ? app_addr_q : app_addr_q + ADDR_W'(ADDR_STEP);
                app_en_d   = !last;
                state_d    = last ? IDLE : RD_CMD;
            end
            default: state_d = CALIB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= CALIB;
            app_en_q      <= 1'b0;
            app_cmd_q     <= '0;
            app_addr_q    <= '0;
            wren_q        <= 1'b0;
            wr_sel_q      <= '0;
            rd_sel_q      <= '0;
            rr_q          <= '0;
            beat_q        <= '0;
            wdata_rd_en_q <= '0;
            wr_ack_q      <= '0;
            rd_ack_q      <= '0;
        end else begin
            state_q       <= state_d;
            app_en_q      <= app_en_d;
            app_cmd_q     <= app_cmd_d;
            app_addr_q    <= app_addr_d;
            wren_q        <= wren_d;
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            rr_q          <= rr_d;
            beat_q        <= beat_d;
            wdata_rd_en_q <= wdata_rd_en_d;
            wr_ack_q      <= wr_ack_d;
            rd_ack_q      <= rd_ack_d;
        end
    end

    assign app_en       = app_en_q;
    assign app_cmd      = app_cmd_q;
    assign app_addr     = app_addr_q;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign app_wdf_mask = '0;
    assign wr_sel       = wr_sel_q;
    assign wdata_rd_en  = wdata_rd_en_q;
    assign wr_ack       = wr_ack_q;
    assign rd_ack       = rd_ack_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter_mp.sv
// tb_mem_arbiter_mp: grant-order vector table plus calibration, stall, wrap and reset-abort sequences
module tb_mem_arbiter_mp;
    localparam int AW = 29;

    logic          clk, reset, calib_done, app_rdy, app_en, app_wdf_rdy, app_wdf_wren, app_wdf_end, busy;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic [15:0]   app_wdf_mask;
    logic          wr_sel;
    logic [1:0]    wdata_rd_en, wr_req, wr_urgent, wr_ack, rd_req, rd_urgent, rd_ack;
    logic [AW-1:0] wa[2], ra[2];
    logic [2*AW-1:0] wr_addr, rd_addr;

    assign wr_addr = {wa[1], wa[0]};
    assign rd_addr = {ra[1], ra[0]};

    mem_arbiter_mp dut (
        .clk(clk), .reset(reset), .calib_done(calib_done), .app_rdy(app_rdy),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .wr_sel(wr_sel), .wdata_rd_en(wdata_rd_en),
        .wr_req(wr_req), .wr_urgent(wr_urgent), .wr_addr(wr_addr), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_urgent(rd_urgent), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .busy(busy)
    );

    typedef struct packed {
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
    } cmd_t;

    typedef struct {
        logic [1:0] wq, rq, wu, ru;
        int         port;
    } vec_t;

    cmd_t    sb[$];
    vec_t    tbl[9];
    int      total = 0, bad = 0;
    int      ack_cnt[4] = '{0, 0, 0, 0};
    int      pop_cnt[2] = '{0, 0};
    int      wren_cnt = 0, end_cnt = 0, en_cnt = 0;
    logic    stall_p = 1'b0;
    logic [2:0]    cmd_p;
    logic [AW-1:0] addr_p;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted command and checks stall hold.
    always @(negedge clk) begin
        if (!reset) begin
            if (app_en && app_rdy) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cmd: got cmd=%0h addr=%0h want none", app_cmd, app_addr);
                end else begin
                    cmd_t e;
                    e = sb.pop_front();
                    chk("cmd", {61'b0, app_cmd}, {61'b0, e.cmd});
                    chk("addr", {35'b0, app_addr}, {35'b0, e.addr});
                end
            end
            if (stall_p)
                chk("stall_hold", {30'b0, app_en, app_cmd, app_addr}, {30'b0, 1'b1, cmd_p, addr_p});
            stall_p = app_en && !app_rdy;
            cmd_p   = app_cmd;
            addr_p  = app_addr;
            for (int i = 0; i < 2; i++) begin
                ack_cnt[i]   += int'(wr_ack[i]);
                ack_cnt[2+i] += int'(rd_ack[i]);
                pop_cnt[i]   += int'(wdata_rd_en[i]);
            end
            wren_cnt += int'(app_wdf_wren);
            end_cnt  += int'(app_wdf_end);
            en_cnt   += int'(app_en);
        end else begin
            stall_p = 1'b0;
        end
    end

    task automatic wait_grant(output int port);
        port = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (|wdata_rd_en) begin
                port = wdata_rd_en[1] ? 1 : 0;
                return;
            end
            if (app_en) begin
                port = app_addr == ra[0] ? 2 : app_addr == ra[1] ? 3 : 9;
                return;
            end
        end
    endtask

    task automatic wait_idle(input bit tog, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (tog) app_rdy = ~app_rdy;
            @(negedge clk); #1;
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_burst(input logic [1:0] wq, rq, wu, ru, input int exp_port, input bit tog, input string nm);
        int a0[4];
        int p0[2];
        int port, sum0, sum1;
        bit ok;
        logic [AW-1:0] base;
        a0   = ack_cnt;
        p0   = pop_cnt;
        base = exp_port < 2 ? wa[exp_port] : ra[exp_port-2];
        for (int b = 0; b < 4; b++)
            sb.push_back('{exp_port < 2 ? 3'b000 : 3'b001, base + AW'(b * 8)});
        @(posedge clk); #1;
        wr_req = wq; rd_req = rq; wr_urgent = wu; rd_urgent = ru;
        wait_grant(port);
        wr_req = '0; rd_req = '0; wr_urgent = '0; rd_urgent = '0;
        chk({nm, "_grant"}, 64'(port), 64'(exp_port));
        wait_idle(tog, ok);
        app_rdy = 1'b1;
        chk({nm, "_idle"}, {63'b0, ok}, 64'd1);
        chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
        sb.delete();
        chk({nm, "_acks"}, 64'(ack_cnt[exp_port] - a0[exp_port]), 64'd4);
        sum0 = a0[0] + a0[1] + a0[2] + a0[3];
        sum1 = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
        chk({nm, "_ack_total"}, 64'(sum1 - sum0), 64'd4);
        if (exp_port < 2)
            chk({nm, "_pops"}, 64'(pop_cnt[exp_port] - p0[exp_port]), 64'd4);
    endtask

    initial begin
        int hold_bad, w0, e0, n0, port;
        tbl[0] = '{2'b11, 2'b11, 2'b00, 2'b00, 0};
        tbl[1] = '{2'b11, 2'b11, 2'b00, 2'b00, 1};
        tbl[2] = '{2'b11, 2'b11, 2'b00, 2'b00, 2};
        tbl[3] = '{2'b11, 2'b11, 2'b00, 2'b00, 3};
        tbl[4] = '{2'b11, 2'b11, 2'b00, 2'b00, 0};
        tbl[5] = '{2'b11, 2'b11, 2'b00, 2'b10, 3};
        tbl[6] = '{2'b11, 2'b11, 2'b00, 2'b00, 0};
        tbl[7] = '{2'b11, 2'b11, 2'b10, 2'b01, 1};
        tbl[8] = '{2'b00, 2'b01, 2'b01, 2'b00, 2};
        reset = 1'b1; calib_done = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        wr_req = '0; rd_req = '0; wr_urgent = '0; rd_urgent = '0;
        wa[0] = 29'h100; wa[1] = 29'h400; ra[0] = 29'h800; ra[1] = 29'h2000;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_outs",
            {21'b0, app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, wdata_rd_en, wr_ack, rd_ack, wr_sel, busy},
            {21'b0, 1'b0, 3'b0, 29'b0, 1'b0, 1'b0, 2'b0, 2'b0, 2'b0, 1'b0, 1'b1});
        chk("reset_mask", {48'b0, app_wdf_mask}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        wr_req = 2'b01;
        hold_bad = 0;
        repeat (20) begin
            @(negedge clk); #1;
            hold_bad += int'(app_en || (|wdata_rd_en) || !busy);
        end
        chk("calib_hold", 64'(hold_bad), 64'd0);
        calib_done = 1'b1;
        run_burst(2'b01, 2'b00, 2'b00, 2'b00, 0, 1'b0, "wr0_first");
        run_burst(2'b00, 2'b10, 2'b00, 2'b00, 3, 1'b1, "rd1_stall");
        for (int i = 0; i < 9; i++)
            run_burst(tbl[i].wq, tbl[i].rq, tbl[i].wu, tbl[i].ru, tbl[i].port, 1'b0, $sformatf("vec%0d", i));

        wa[0] = 29'h1FFFFFF8;
        app_wdf_rdy = 1'b0;
        sb.push_back('{3'b000, 29'h1FFFFFF8});
        sb.push_back('{3'b000, 29'h0});
        sb.push_back('{3'b000, 29'h8});
        sb.push_back('{3'b000, 29'h10});
        w0 = wren_cnt; e0 = end_cnt;
        @(posedge clk); #1;
        wr_req = 2'b01;
        wait_grant(port);
        wr_req = '0;
        chk("wrap_grant", 64'(port), 64'd0);
        repeat (5) @(negedge clk);
        #1;
        app_wdf_rdy = 1'b1;
        for (int i = 0; i < 50 && sb.size() > 3; i++) begin
            @(negedge clk); #1;
        end
        chk("wrap_wren_cycles", 64'(wren_cnt - w0), 64'd6);
        chk("wrap_end_cycles", 64'(end_cnt - e0), 64'd6);
        for (int i = 0; i < 50 && sb.size() > 2; i++) begin
            @(negedge clk); #1;
        end
        chk("wrap_two_cmds", 64'(sb.size()), 64'd2);
        @(negedge clk); #1;
        reset = 1'b1;
        calib_done = 1'b0;
        @(negedge clk); #1;
        chk("abort_outs",
            {29'b0, app_en, app_wdf_wren, wdata_rd_en, wr_ack, rd_ack, busy, app_addr},
            {29'b0, 1'b0, 1'b0, 2'b0, 2'b0, 2'b0, 1'b1, 29'b0});
        sb.delete();
        reset = 1'b0;
        n0 = en_cnt;
        hold_bad = 0;
        repeat (10) begin
            @(negedge clk); #1;
            hold_bad += int'(!busy || (|wdata_rd_en));
        end
        chk("abort_no_cmds", 64'(en_cnt - n0), 64'd0);
        chk("abort_calib_wait", 64'(hold_bad), 64'd0);
        calib_done = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("recal_idle", {63'b0, busy}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
